// File: rtl/multi_button_debounce.sv
// N_CH-channel button debouncer with press/release pulses, lock masking and a lowest-index press encoder.
// Optional auto-repeat on held buttons is enabled by defining MULTI_BUTTON_DEBOUNCE_REPEAT_EN.
module multi_button_debounce #(
  parameter int N_CH            = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10,
  localparam int IDX_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [N_CH-1:0]   button,
  input  logic              lock,
  output logic [N_CH-1:0]   level,
  output logic [N_CH-1:0]   press,
  output logic [N_CH-1:0]   release_pulse,
  output logic              press_any,
  output logic [IDX_W-1:0]  press_idx
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          s1, s2, lvl, prs, rls;
    logic [CW-1:0] cnt;
    logic          done, rise, fall, rep;

    // The counter only runs while the synchronised input disagrees with the debounced level.
    assign done = (s2 != lvl) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise = done && !lvl;
    assign fall = done && lvl;

`ifdef MULTI_BUTTON_DEBOUNCE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(RMAX + 1);
    logic [TW-1:0] tmr;
    logic          phase;

    // phase=0 waits out the initial delay, phase=1 paces the periodic repeats; lock does not stall it.
    assign rep = lvl && !fall &&
                 (phase ? (tmr == TW'(REPEAT_PERIOD - 1)) : (tmr == TW'(REPEAT_DELAY - 1)));

    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
        tmr   <= '0;
        phase <= 1'b0;
      end else if (!lvl) begin
        tmr   <= '0;
        phase <= 1'b0;
      end else if (rep) begin
        tmr   <= '0;
        phase <= 1'b1;
      end else begin
        tmr   <= tmr + 1'b1;
      end
    end
`else
    assign rep = 1'b0;
`endif

    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        lvl <= 1'b0;
        cnt <= '0;
        prs <= 1'b0;
        rls <= 1'b0;
      end else begin
        s1 <= button[i];
        s2 <= s1;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (done) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        prs <= !lock && (rise || rep);
        rls <= !lock && fall;
      end
    end

    assign level[i]         = lvl;
    assign press[i]         = prs;
    assign release_pulse[i] = rls;
  end

  // Scan from the top so the lowest set index wins.
  always_comb begin
    press_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (press[i]) press_idx = IDX_W'(i);
    end
  end

  assign press_any = |press;

endmodule
